de2_io_controller: RTL

Board-side endpoint of the DE2 push-button/switch protocol, sitting inside the DE2 wrapper between the board pins and the MIMD array's I/O port. It conditions the active-low KEY buttons and, on a debounced SW-button press, hands the 16-bit switch value to the processor through a valid/ready handshake. On a debounced OUT-button press, it pops the next processor result from a small output FIFO into the display register that drives LEDR and the HEX decoders.

---
 rtl/de2_io_pkg.sv | 20 ++
 rtl/key_debounce.sv | 52 +++++
 rtl/de2_io_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/de2_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : de2_io_pkg
// Description : Shared types and constants for the DE2 board I/O controller.
// Revision    : 1.0 - initial release
// ============================================================================
package de2_io_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sw_state_t;

  localparam int KEY_SW  = 0;
  localparam int KEY_OUT = 1;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronizes and debounces one active-low button and emits a
//               one-clock pulse on each debounced press.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Level only flips on the edge after DEBOUNCE_CYCLES full clocks of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/de2_io_controller.sv
`default_nettype none
// ============================================================================
// Module      : de2_io_controller
// Description : DE2 push-button/switch endpoint: SW word handoff to the
//               processor and output FIFO feeding the LEDR/HEX display.
// Revision    : 1.0 - initial release
// ============================================================================
module de2_io_controller
  import de2_io_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 250,
  parameter int OUT_DEPTH       = 4
) (
  input  logic                           CLOCK_50,
  input  logic                           nReset,
  input  logic [DATA_W-1:0]              SW,
  input  logic [1:0]                     KEY,
  output logic [DATA_W-1:0]              in_data,
  output logic                           in_valid,
  input  logic                           in_ready,
  input  logic [DATA_W-1:0]              out_data,
  input  logic                           out_valid,
  output logic                           out_ready,
  output logic [DATA_W-1:0]              disp_data,
  output logic [$clog2(OUT_DEPTH+1)-1:0] fifo_count,
  output logic                           sw_overrun
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  logic w_sw_press;
  logic w_out_press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_sw (
    .clk     (CLOCK_50),
    .rst_n   (nReset),
    .i_key_n (KEY[KEY_SW]),
    .o_press (w_sw_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_out (
    .clk     (CLOCK_50),
    .rst_n   (nReset),
    .i_key_n (KEY[KEY_OUT]),
    .o_press (w_out_press)
  );

  // ---------------------------------------------------------------- SW path
  sw_state_t         r_state;
  logic [DATA_W-1:0] r_in_data;
  logic              r_in_valid;
  logic              r_overrun;

  // Any press outside IDLE, including the handshake cycle itself, is dropped.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      r_state    <= IDLE;
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sw_press) begin
            r_in_data  <= SW;
            r_in_valid <= 1'b1;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (w_sw_press) r_overrun <= 1'b1;
          if (in_ready) begin
            r_in_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_data    = r_in_data;
  assign in_valid   = r_in_valid;
  assign sw_overrun = r_overrun;

  // --------------------------------------------------------------- OUT path
  logic [DATA_W-1:0] r_mem [OUT_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_out_ready;
  logic [DATA_W-1:0] r_disp;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_next;

  // Pop qualifies on the pre-push count, so it never sees a same-cycle push.
  assign w_push = out_valid && r_out_ready;
  assign w_pop  = w_out_press && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wr_ptr] <= out_data;
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_ready <= 1'b1;
      r_disp      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_disp   <= r_mem[r_rd_ptr];
      end
      r_count     <= w_count_next;
      r_out_ready <= (w_count_next != CNT_W'(OUT_DEPTH));
    end
  end

  assign out_ready  = r_out_ready;
  assign disp_data  = r_disp;
  assign fifo_count = r_count;

endmodule
`default_nettype wire
